// File: rtl/serial_defs.sv
// Shared definitions for the serial link: FSM state encodings, line levels
// and a counter-width helper used by both the transmitter and the receiver.
package serial_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Width needed to count 0..range-1, never less than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Load-side handshake for the serial transmitter.
// A word transfers on a rising edge where load_valid && load_ready; the
// sender holds load_valid and din stable until that edge.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              load_valid;
    logic              load_ready;

    modport master (output din, output load_valid, input load_ready);
    modport slave  (input din, input load_valid, output load_ready);
endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and pulses
// bit_end on the terminal count. Held at zero whenever run is low.
module serial_bit_timer
    import serial_defs::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end
);
    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_end = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits
// LSB first, stop bit, each held CLKS_PER_BIT clocks. Line idles high.
module serial_tx
    import serial_defs::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    serial_tx_if.slave  load,
    output logic        txd,
    output logic        busy,
    output logic        done,
    output state_t      dbg_state
);
    localparam int IDX_W = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [IDX_W-1:0]  bit_idx;
    logic              bit_end;

    assign load.load_ready = (state == IDLE);
    assign dbg_state       = state;
    assign shreg_next      = shreg >> 1;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state != IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            txd     <= LINE_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load.load_valid) begin
                        shreg <= load.din;
                        state <= START;
                        txd   <= START_BIT;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                            txd   <= STOP_BIT;
                        end else begin
                            // Next bit comes from the shifted word, so txd and shreg move together.
                            shreg   <= shreg_next;
                            txd     <= shreg_next[0];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one DUT at CLKS_PER_BIT=4, one at 1, with a
// per-cycle expected txd queue filled when each word is offered.
module tb_serial_tx;
    import serial_defs::*;

    logic clk;
    logic rst;
    logic txd_a, busy_a, done_a;
    logic txd_b, busy_b, done_b;
    state_t st_a, st_b;

    int tests;
    int fails;
    logic [0:0] exp_q[$];

    serial_tx_if #(.DATA_W(8)) if_a ();
    serial_tx_if #(.DATA_W(8)) if_b ();

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .load(if_a), .txd(txd_a), .busy(busy_a),
        .done(done_a), .dbg_state(st_a)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(rst), .load(if_b), .txd(txd_b), .busy(busy_b),
        .done(done_b), .dbg_state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            if_b.load_valid = v;
            if_b.din        = d;
        end else begin
            if_a.load_valid = v;
            if_a.din        = d;
        end
    endtask

    // {txd, busy, done, load_ready}
    function automatic logic [3:0] obs(input bit sel);
        return sel ? {txd_b, busy_b, done_b, if_b.load_ready}
                   : {txd_a, busy_a, done_a, if_a.load_ready};
    endfunction

    task automatic push_frame(input int cpb, input logic [7:0] d);
        for (int b = 0; b < 10; b++) begin
            logic bitv;
            if (b == 0)      bitv = START_BIT;
            else if (b == 9) bitv = STOP_BIT;
            else             bitv = d[b-1];
            for (int k = 0; k < cpb; k++) exp_q.push_back(bitv);
        end
    endtask

    // Called right after the accept edge has been set up; walks the whole
    // frame plus the done cycle. busy_v/busy_d are driven during the frame.
    task automatic watch_frame(input bit sel, input int cpb, input logic [7:0] d,
                               input logic busy_v, input logic [7:0] busy_d,
                               input logic keep_after, input string tag);
        logic [3:0] o;
        push_frame(cpb, d);
        for (int c = 0; c < 10 * cpb; c++) begin
            @(negedge clk);
            drive(sel, busy_v, busy_d);
            o = obs(sel);
            check({tag, "_txd"}, {31'd0, o[3]}, {31'd0, exp_q.pop_front()});
            check({tag, "_busy"}, {31'd0, o[2]}, 32'd1);
            check({tag, "_done_early"}, {31'd0, o[1]}, 32'd0);
            check({tag, "_ready_busy"}, {31'd0, o[0]}, 32'd0);
        end
        @(negedge clk);
        o = obs(sel);
        check({tag, "_txd_donecyc"}, {31'd0, o[3]}, 32'd1);
        check({tag, "_busy_donecyc"}, {31'd0, o[2]}, 32'd0);
        check({tag, "_done"}, {31'd0, o[1]}, 32'd1);
        check({tag, "_ready_donecyc"}, {31'd0, o[0]}, 32'd1);
        drive(sel, keep_after, busy_d);
    endtask

    initial begin
        logic [3:0] o;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        drive(0, 1'b1, 8'h55);
        drive(1, 1'b1, 8'h55);

        // Reset held two edges with load_valid high: nothing accepted
        repeat (2) begin
            @(negedge clk);
            o = obs(0);
            check("rst_txd", {31'd0, o[3]}, 32'd1);
            check("rst_busy", {31'd0, o[2]}, 32'd0);
            check("rst_done", {31'd0, o[1]}, 32'd0);
            check("rst_ready", {31'd0, o[0]}, 32'd1);
            o = obs(1);
            check("rst_b_txd", {31'd0, o[3]}, 32'd1);
            check("rst_b_busy", {31'd0, o[2]}, 32'd0);
        end
        rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        @(negedge clk);
        o = obs(0);
        check("post_rst_txd", {31'd0, o[3]}, 32'd1);
        check("post_rst_busy", {31'd0, o[2]}, 32'd0);
        check("post_rst_ready", {31'd0, o[0]}, 32'd1);

        // Single frame
        drive(0, 1'b1, 8'hA5);
        watch_frame(0, 4, 8'hA5, 1'b0, 8'hA5, 1'b0, "a5");
        @(negedge clk);
        o = obs(0);
        check("a5_done_once", {31'd0, o[1]}, 32'd0);
        check("a5_idle_txd", {31'd0, o[3]}, 32'd1);

        // Back-to-back with load_valid held: second accept on the done cycle
        drive(0, 1'b1, 8'h00);
        watch_frame(0, 4, 8'h00, 1'b1, 8'hFF, 1'b1, "b2b0");
        watch_frame(0, 4, 8'hFF, 1'b0, 8'hFF, 1'b0, "b2b1");
        @(negedge clk);

        // Offer a different word throughout the frame; it must be ignored
        drive(0, 1'b1, 8'h3C);
        watch_frame(0, 4, 8'h3C, 1'b1, 8'hC3, 1'b0, "busy");
        @(negedge clk);
        o = obs(0);
        check("busy_no_accept", {31'd0, o[2]}, 32'd0);
        check("busy_ready_after", {31'd0, o[0]}, 32'd1);

        // Reset during data bit 3
        drive(0, 1'b1, 8'h96);
        push_frame(4, 8'h96);
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            drive(0, 1'b0, 8'h96);
            o = obs(0);
            check("mid_txd", {31'd0, o[3]}, {31'd0, exp_q.pop_front()});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        o = obs(0);
        check("mid_rst_txd", {31'd0, o[3]}, 32'd1);
        check("mid_rst_busy", {31'd0, o[2]}, 32'd0);
        check("mid_rst_done", {31'd0, o[1]}, 32'd0);
        check("mid_rst_ready", {31'd0, o[0]}, 32'd1);
        repeat (6) begin
            @(negedge clk);
            o = obs(0);
            check("mid_no_done", {31'd0, o[1]}, 32'd0);
            check("mid_idle_txd", {31'd0, o[3]}, 32'd1);
        end
        drive(0, 1'b1, 8'h5A);
        watch_frame(0, 4, 8'h5A, 1'b0, 8'h5A, 1'b0, "after_rst");
        @(negedge clk);

        // One clock per bit
        drive(1, 1'b1, 8'h81);
        watch_frame(1, 1, 8'h81, 1'b0, 8'h81, 1'b0, "cpb1");
        @(negedge clk);
        o = obs(1);
        check("cpb1_done_once", {31'd0, o[1]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
